// File: rtl/ram128_bit_reader.sv
// ============================================================================
// Module   : ram128_bit_reader
// Brief    : Sweeps an address range of a 128x1 RAM read port and packs the
//            bits LSB-first into OUT_W-bit words on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram128_bit_reader #(
    parameter int OUT_W = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [6:0]       start_addr,
    input  logic [7:0]       start_len,
    output logic [6:0]       rd_addr,
    input  logic             rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(OUT_W + 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_rd_addr;
    logic [7:0]       r_rem;
    logic [IDX_W-1:0] r_idx;
    logic [OUT_W-1:0] r_sr;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;

    logic [7:0]       w_len;
    logic             w_sample;
    logic             w_xfer;
    logic [OUT_W-1:0] w_word;

    assign w_len = (start_len > 8'd128) ? 8'd128 : start_len;

    always_comb begin
        w_next   = r_state;
        // A bit that completes a word may only be taken if the output register can receive it.
        w_sample = (r_state == S_READ) &&
                   (((r_idx < c_IDX_LAST) && (r_rem > 8'd1)) || !r_out_valid || out_ready);
        w_xfer   = w_sample && ((r_idx == c_IDX_LAST) || (r_rem == 8'd1));
        w_word   = r_sr | (OUT_W'(rd_data) << r_idx);
        case (r_state)
            S_IDLE:  if (start_valid && (w_len != 8'd0)) w_next = S_READ;
            S_READ:  if (w_xfer && (r_rem == 8'd1)) w_next = S_DRAIN;
            S_DRAIN: if (r_out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr   <= 7'd0;
            r_rem       <= 8'd0;
            r_idx       <= '0;
            r_sr        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_rd_addr <= start_addr;
                        r_rem     <= w_len;
                        r_idx     <= '0;
                        r_sr      <= '0;
                        if (w_len == 8'd0) r_done <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_sample) begin
                        r_rd_addr <= r_rd_addr + 7'd1;
                        r_rem     <= r_rem - 8'd1;
                        if (w_xfer) begin
                            r_out_data  <= w_word;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_rem == 8'd1);
                            r_idx       <= '0;
                            r_sr        <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_sr  <= w_word;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rd_addr     = r_rd_addr;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram128_bit_reader.sv
// ============================================================================
// Module   : tb_ram128_bit_reader
// Brief    : Directed and randomized checks of ram128_bit_reader against a
//            RAM-contents-based word model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram128_bit_reader;

    localparam int W = 8;

    logic         CLK;
    logic         reset_n;
    logic         start_valid;
    logic         start_ready;
    logic [6:0]   start_addr;
    logic [7:0]   start_len;
    logic [6:0]   rd_addr;
    logic         rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    logic [127:0] ram;
    int n_total = 0;
    int n_pass  = 0;

    assign rd_data = ram[rd_addr];

    ram128_bit_reader #(.OUT_W(W)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_addr(start_addr), .start_len(start_len),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " rd_addr"},     32'(rd_addr),     32'd0);
        chk({tag, " out_valid"},   32'(out_valid),   32'd0);
        chk({tag, " out_data"},    32'(out_data),    32'd0);
        chk({tag, " out_last"},    32'(out_last),    32'd0);
        chk({tag, " busy"},        32'(busy),        32'd0);
        chk({tag, " done"},        32'(done),        32'd0);
        chk({tag, " start_ready"}, 32'(start_ready), 32'd1);
    endtask

    // Word w of a command: bit i is RAM[(addr + w*W + i) mod 128] for the first n bits, else 0.
    function automatic logic [31:0] exp_word(input int addr, input int n, input int w);
        logic [31:0] v;
        int b;
        v = '0;
        for (int i = 0; i < W; i++) begin
            b = w * W + i;
            if (b < n) v[i] = ram[(addr + b) % 128];
        end
        return v;
    endfunction

    task automatic randomize_ram();
        for (int i = 0; i < 128; i++) ram[i] = 1'($urandom % 2);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 10 cycles after first valid.
    task automatic run_cmd(input string tag, input int addr, input int len, input int mode, input bit hold_start);
        logic [31:0] got_data[$];
        logic        got_last[$];
        int n, nwords, holdcnt, cyc;
        bit seen_valid, prev_stall, finished;
        logic [W-1:0] prev_data;
        n = (len > 128) ? 128 : len;
        nwords = (n + W - 1) / W;
        holdcnt = 0; seen_valid = 0; prev_stall = 0; finished = 0; prev_data = '0;
        start_addr  = 7'(addr);
        start_len   = 8'(len);
        start_valid = 1'b1;
        chk({tag, " start_ready idle"}, 32'(start_ready), 32'd1);
        step();
        start_valid = hold_start;
        start_addr  = ~7'(addr);
        start_len   = 8'd9;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (done) begin
                finished = 1;
                break;
            end
            if (hold_start) chk({tag, " start_ready busy"}, 32'(start_ready), 32'd0);
            if (prev_stall) begin
                chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
                chk({tag, " hold data"},  32'(out_data),  32'(prev_data));
            end
            if (out_valid) seen_valid = 1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom % 3) != 0;
                default: begin
                    out_ready = !(seen_valid && holdcnt < 10);
                    // Word 1 bits 0..6 are taken freely; bit 7 waits for a free output register.
                    if (seen_valid && holdcnt == 9 && n >= 16)
                        chk({tag, " stall addr"}, 32'(rd_addr), 32'((addr + 15) % 128));
                    if (seen_valid) holdcnt++;
                end
            endcase
            if (out_valid && out_ready) begin
                got_data.push_back(32'(out_data));
                got_last.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        start_valid = 1'b0;
        chk({tag, " finished"}, 32'(finished), 32'd1);
        chk({tag, " word count"}, 32'(got_data.size()), 32'(nwords));
        for (int w = 0; w < got_data.size() && w < nwords; w++) begin
            chk($sformatf("%s word%0d data", tag, w), got_data[w], exp_word(addr, n, w));
            chk($sformatf("%s word%0d last", tag, w), 32'(got_last[w]), 32'(w == nwords - 1));
        end
        if (n > 0) chk({tag, " end addr"}, 32'(rd_addr), 32'((addr + n) % 128));
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start_valid = 1'b0; start_addr = '0; start_len = '0;
        out_ready = 1'b0; ram = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset");
        reset_n = 1'b1;
        step();

        // Basic single word
        ram = '0;
        ram[7:0] = 8'h4D;
        out_ready = 1'b1;
        start_addr = 7'd0; start_len = 8'd8; start_valid = 1'b1;
        chk("basic start_ready", 32'(start_ready), 32'd1);
        step();
        start_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("basic valid@%0d", k), 32'(out_valid), 32'(k == 8));
        end
        chk("basic data", 32'(out_data), 32'h4D);
        chk("basic last", 32'(out_last), 32'd1);
        chk("basic busy", 32'(busy), 32'd1);
        step();
        chk("basic done", 32'(done), 32'd1);
        chk("basic valid clr", 32'(out_valid), 32'd0);
        chk("basic busy clr", 32'(busy), 32'd0);
        step();
        chk("basic done 1cyc", 32'(done), 32'd0);

        // Wrap and partial word
        ram = '0;
        ram[126] = 1'b1; ram[127] = 1'b1; ram[0] = 1'b0; ram[1] = 1'b1; ram[2] = 1'b1;
        start_addr = 7'd126; start_len = 8'd5; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrap addr%0d", k), 32'(rd_addr), 32'((126 + k) % 128));
            step();
        end
        chk("wrap valid", 32'(out_valid), 32'd1);
        chk("wrap data",  32'(out_data),  32'h1B);
        chk("wrap last",  32'(out_last),  32'd1);
        step();
        chk("wrap done", 32'(done), 32'd1);

        // Backpressure
        randomize_ram();
        run_cmd("bp", 10, 16, 2, 1'b0);

        // Zero length
        start_addr = 7'd33; start_len = 8'd0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        chk("zero done",  32'(done),      32'd1);
        chk("zero valid", 32'(out_valid), 32'd0);
        chk("zero busy",  32'(busy),      32'd0);
        step();
        chk("zero done 1cyc", 32'(done),      32'd0);
        chk("zero valid2",    32'(out_valid), 32'd0);

        // Start ignored while busy; clamp of oversize length
        randomize_ram();
        run_cmd("busy", 50, 12, 0, 1'b1);
        randomize_ram();
        run_cmd("clamp", 100, 200, 1, 1'b0);

        // Abort after 3 bits with asynchronous reset
        out_ready = 1'b1;
        start_addr = 7'd40; start_len = 8'd20; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (3) step();
        #3;
        reset_n = 1'b0;
        #1;
        check_reset("abort");
        #1;
        reset_n = 1'b1;
        step();
        randomize_ram();
        run_cmd("post-abort", 77, 13, 1, 1'b0);

        // Randomized commands
        for (int r = 0; r < 8; r++) begin
            randomize_ram();
            run_cmd($sformatf("rand%0d", r), int'($urandom % 128), int'($urandom % 141), 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
